// File: rtl/spram_stream_reader.sv
// Reads a contiguous, wrapping range of words from a single-port SPRAM and
// presents them as a valid/ready stream through a 2-entry skid FIFO.
module spram_stream_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W:0]   len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_en_o,
  output logic [3:0]        mem_mask_we_o,
  input  logic [DATA_W-1:0] mem_rd_data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic              m_last_o
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_ZERO = '0;
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W:0]   beats_q;
  logic              arm_q;
  logic              inflight_q;
  logic              busy_q;
  logic              done_q;
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        count_q;
  logic [1:0]        count_d;
  logic [1:0]        occ_sum;
  logic              pop;
  logic              push;
  logic              issue;
  logic              last_pop;

  assign pop      = (count_q != 2'd0) && m_ready_i;
  assign push     = inflight_q;
  assign last_pop = pop && (beats_q == CNT_ONE);

  // Words already buffered or on their way must leave room for the next read,
  // so the FIFO can never overflow and no read ever has to be repeated.
  assign occ_sum = count_q + {1'b0, inflight_q} - {1'b0, pop};
  assign issue   = (state_q == RUN) && !arm_q && (remaining_q != CNT_ZERO)
                   && (occ_sum < 2'd2);

  assign count_d = count_q + {1'b0, push} - {1'b0, pop};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_entry
      logic [DATA_W-1:0] data_q;
      always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
          data_q <= '0;
        end else if (push && (wr_ptr_q == 1'(gi))) begin
          data_q <= mem_rd_data_i;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      beats_q     <= '0;
      arm_q       <= 1'b0;
      inflight_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      done_q     <= 1'b0;
      arm_q      <= 1'b0;
      inflight_q <= issue;
      count_q    <= count_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
        beats_q  <= beats_q - CNT_ONE;
      end
      if (issue) begin
        addr_q      <= addr_q + ADDR_ONE;
        remaining_q <= remaining_q - CNT_ONE;
      end
      case (state_q)
        IDLE: begin
          // A start coinciding with the done pulse belongs to the old command.
          if (start_i && !done_q) begin
            if (len_i != CNT_ZERO) begin
              addr_q      <= base_addr_i;
              remaining_q <= len_i;
              beats_q     <= len_i;
              arm_q       <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= RUN;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (remaining_q == CNT_ONE)) state_q <= DRAIN;
        end
        DRAIN: begin
          if (last_pop) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign mem_addr_o    = addr_q;
  assign mem_wr_en_o   = 1'b0;
  assign mem_mask_we_o = 4'b0000;
  assign m_valid_o     = (count_q != 2'd0);
  assign m_data_o      = rd_ptr_q ? g_entry[1].data_q : g_entry[0].data_q;
  assign m_last_o      = m_valid_o && (beats_q == CNT_ONE);

endmodule
